// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between a request sequencer, mem_access_ctrl and a one-hot
// addressed register-file memory.
interface mem_access_ctrl_if #(
  parameter int WORDS  = 4,
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;
  logic [WORDS-1:0]  mem_add;
  logic              mem_rw;
  logic [WIDTH-1:0]  mem_din;
  logic [WIDTH-1:0]  mem_dout;
  logic              busy;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_add, mem_rw, mem_din, busy
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_add, mem_rw, mem_din, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for the one-hot addressed register-file memory: one request in,
// a DRIVE -> STROBE/CAPTURE -> RESP sequence, one response pulse out.
module mem_access_ctrl #(
  parameter int WORDS  = 4,
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, STROBE, CAPTURE, RESP} state_t;

  state_t           state_q;
  logic             rw_q;
  logic             err_q;
  logic [WIDTH-1:0] wdata_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [WORDS-1:0] mem_add_q;
  logic             mem_rw_q;
  logic [WIDTH-1:0] mem_din_q;
  logic             err_d;
  logic [WORDS-1:0] sel_d;

  // Out-of-range addresses select no word at all, so they can never be strobed.
  always_comb begin
    err_d = (int'(bus.req_addr) >= WORDS);
    sel_d = err_d ? '0 : (WORDS'(1) << bus.req_addr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_add_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            rw_q        <= bus.req_rw;
            err_q       <= err_d;
            wdata_q     <= bus.req_wdata;
            mem_add_q   <= sel_d;
            mem_din_q   <= bus.req_rw ? bus.req_wdata : '0;
            req_ready_q <= 1'b0;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          if (rw_q) begin
            mem_rw_q <= ~err_q;
            state_q  <= STROBE;
          end else begin
            state_q  <= CAPTURE;
          end
        end
        STROBE: begin
          mem_rw_q    <= 1'b0;
          mem_add_q   <= '0;
          mem_din_q   <= '0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= wdata_q;
          rsp_err_q   <= err_q;
          state_q     <= RESP;
        end
        CAPTURE: begin
          mem_add_q   <= '0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= err_q ? '0 : bus.mem_dout;
          rsp_err_q   <= err_q;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = ~req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_add   = mem_add_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 4-word instance plus a 3-word
// instance for out-of-range addressing, each wired to a small memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   badStrobes  = 0;
  int   strobes3    = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.WORDS(4), .WIDTH(4), .ADDR_W(2)) bus ();
  mem_access_ctrl_if #(.WORDS(3), .WIDTH(4), .ADDR_W(2)) bus3 ();

  mem_access_ctrl #(.WORDS(4), .WIDTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
  mem_access_ctrl #(.WORDS(3), .WIDTH(4), .ADDR_W(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.master));

  logic [3:0] mem4 [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] mem3 [3] = '{4'b1010, 4'b0011, 4'b0110};

  // Memory models commit on the posedge of a strobe cycle; illegal strobes are counted.
  always @(posedge clk) begin
    if (bus.mem_rw) begin
      if (!$onehot(bus.mem_add)) badStrobes <= badStrobes + 1;
      for (int i = 0; i < 4; i++) if (bus.mem_add[i]) mem4[i] <= bus.mem_din;
    end
    if (bus3.mem_rw) begin
      strobes3 <= strobes3 + 1;
      for (int i = 0; i < 3; i++) if (bus3.mem_add[i]) mem3[i] <= bus3.mem_din;
    end
  end

  always_comb begin
    bus.mem_dout  = '0;
    bus3.mem_dout = '0;
    for (int i = 0; i < 4; i++) if (bus.mem_add[i]) bus.mem_dout = bus.mem_dout | mem4[i];
    for (int i = 0; i < 3; i++) if (bus3.mem_add[i]) bus3.mem_dout = bus3.mem_dout | mem3[i];
  end

  // Issues one request on the 4-word bus, returns the response, ends back in IDLE.
  task automatic doRequest(input logic rw, input logic [1:0] addr, input logic [3:0] wdata,
                           output logic [3:0] rdata, output logic err, output logic ok);
    logic wasReady;
    logic accepted;
    logic got;
    accepted = 1'b0;
    got      = 1'b0;
    rdata    = '0;
    err      = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int c = 0; c < 20 && !accepted; c++) begin
      wasReady = bus.req_ready;
      @(negedge clk);
      accepted = wasReady;
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 8 && accepted && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got   = 1'b1;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
      end
    end
    @(negedge clk);
    ok = accepted && got;
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b1;
    bus.req_rw     = 1'b0;
    bus.req_addr   = 2'd0;
    bus.req_wdata  = 4'hF;
    bus3.req_valid = 1'b0;
    bus3.req_rw    = 1'b0;
    bus3.req_addr  = 2'd0;
    bus3.req_wdata = 4'h0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      testsRun++;
      if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
           bus.mem_add, bus.mem_rw, bus.mem_din} !== {3'b100, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0}) begin
        testsFailed++;
        $display("[TB] FAIL reset_state: got rdy=%b busy=%b rv=%b rd=%h err=%b add=%b rw=%b din=%h, want rdy=1 rest 0",
                 bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                 bus.mem_add, bus.mem_rw, bus.mem_din);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({bus.req_ready, bus.busy, bus.mem_add} !== {1'b0, 1'b1, 4'b0001}) begin
      testsFailed++;
      $display("[TB] FAIL first_accept: got rdy=%b busy=%b add=%b, want rdy=0 busy=1 add=0001",
               bus.req_ready, bus.busy, bus.mem_add);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_return_idle: got rdy=%b, want 1", bus.req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [3:0] rd;
    logic       er;
    logic       ok;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 2'd2;
    bus.req_wdata = 4'b0101;
    @(negedge clk);
    bus.req_valid = 1'b0;
    testsRun++;
    if ({bus.req_ready, bus.busy, bus.mem_add, bus.mem_rw, bus.mem_din, bus.rsp_valid}
        !== {1'b0, 1'b1, 4'b0100, 1'b0, 4'b0101, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL write_drive: got rdy=%b busy=%b add=%b rw=%b din=%b rv=%b, want 0 1 0100 0 0101 0",
               bus.req_ready, bus.busy, bus.mem_add, bus.mem_rw, bus.mem_din, bus.rsp_valid);
    end
    @(negedge clk);
    testsRun++;
    if ({bus.mem_add, bus.mem_rw, bus.mem_din, bus.rsp_valid} !== {4'b0100, 1'b1, 4'b0101, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL write_strobe: got add=%b rw=%b din=%b rv=%b, want 0100 1 0101 0",
               bus.mem_add, bus.mem_rw, bus.mem_din, bus.rsp_valid);
    end
    @(negedge clk);
    testsRun++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.mem_add, bus.mem_rw}
        !== {1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL write_resp: got rv=%b rd=%b err=%b add=%b rw=%b, want 1 0101 0 0000 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.mem_add, bus.mem_rw);
    end
    @(negedge clk);
    testsRun++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.busy}
        !== {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL write_idle: got rv=%b rd=%b err=%b rdy=%b busy=%b, want 0 0000 0 1 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.busy);
    end
    testsRun++;
    if (mem4[2] !== 4'b0101) begin
      testsFailed++;
      $display("[TB] FAIL write_commit: got mem[2]=%b, want 0101", mem4[2]);
    end
    doRequest(1'b0, 2'd2, 4'b0000, rd, er, ok);
    testsRun++;
    if ({ok, rd, er} !== {1'b1, 4'b0101, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL read_addr2: got ok=%b rd=%b err=%b, want 1 0101 0", ok, rd, er);
    end
  endtask

  task automatic test_all_words();
    logic [3:0] rd;
    logic       er;
    logic       ok;
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 4'b0001 << i;
      doRequest(1'b1, 2'(i), d, rd, er, ok);
      testsRun++;
      if ({ok, rd, er} !== {1'b1, d, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL all_write[%0d]: got ok=%b rd=%b err=%b, want 1 %b 0", i, ok, rd, er, d);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      d = 4'b0001 << i;
      doRequest(1'b0, 2'(i), 4'b1111, rd, er, ok);
      testsRun++;
      if ({ok, rd, er} !== {1'b1, d, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL all_read[%0d]: got ok=%b rd=%b err=%b, want 1 %b 0", i, ok, rd, er, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] addrs [3] = '{2'd3, 2'd2, 2'd1};
    logic [3:0] expD  [3] = '{4'b1000, 4'b0100, 4'b0010};
    logic [3:0] got   [3] = '{4'h0, 4'h0, 4'h0};
    int         accAt [3] = '{-1, -1, -1};
    int         nAcc   = 0;
    int         nRsp   = 0;
    int         nReady = 0;
    logic       wasReady;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = addrs[0];
    for (int c = 0; c < 12; c++) begin
      wasReady = bus.req_ready && bus.req_valid;
      @(negedge clk);
      if (wasReady) begin
        if (nAcc < 3) accAt[nAcc] = c;
        nAcc++;
        if (nAcc < 3) bus.req_addr = addrs[nAcc];
        else bus.req_valid = 1'b0;
      end
      if (bus.req_ready) nReady++;
      if (bus.rsp_valid) begin
        if (nRsp < 3) got[nRsp] = bus.rsp_rdata;
        nRsp++;
      end
    end
    bus.req_valid = 1'b0;
    testsRun++;
    if (nAcc !== 3 || accAt[0] !== 0 || accAt[1] !== 4 || accAt[2] !== 8) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accepts: got n=%0d at %0d,%0d,%0d, want 3 at 0,4,8",
               nAcc, accAt[0], accAt[1], accAt[2]);
    end
    testsRun++;
    if (nReady !== 3 || nRsp !== 3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_counts: got ready=%0d rsp=%0d, want 3 3", nReady, nRsp);
    end
    for (int k = 0; k < 3; k++) begin
      testsRun++;
      if (got[k] !== expD[k]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_rsp[%0d]: got %b, want %b", k, got[k], expD[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic       rwT   [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] addrT [3] = '{2'd3, 2'd0, 2'd3};
    logic [3:0] wdT   [3] = '{4'b1111, 4'b0000, 4'b0000};
    logic [3:0] expD  [3] = '{4'b1111, 4'b1010, 4'b0000};
    logic       expE  [3] = '{1'b1, 1'b0, 1'b1};
    logic       anySel;
    logic       rv;
    logic [3:0] rd;
    logic       er;
    anySel = 1'b0;
    for (int t = 0; t < 3; t++) begin
      rv = 1'b0;
      rd = '0;
      er = 1'b0;
      bus3.req_valid = 1'b1;
      bus3.req_rw    = rwT[t];
      bus3.req_addr  = addrT[t];
      bus3.req_wdata = wdT[t];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0) bus3.req_valid = 1'b0;
        if (expE[t] && (bus3.mem_add != 3'b000 || bus3.mem_rw)) anySel = 1'b1;
        if (c == 2) begin
          rv = bus3.rsp_valid;
          rd = bus3.rsp_rdata;
          er = bus3.rsp_err;
        end
      end
      testsRun++;
      if ({rv, rd, er} !== {1'b1, expD[t], expE[t]}) begin
        testsFailed++;
        $display("[TB] FAIL oor_rsp[%0d]: got rv=%b rd=%b err=%b, want 1 %b %b",
                 t, rv, rd, er, expD[t], expE[t]);
      end
    end
    testsRun++;
    if (anySel !== 1'b0 || strobes3 !== 0 || mem3[2] !== 4'b0110) begin
      testsFailed++;
      $display("[TB] FAIL oor_no_access: got sel=%b strobes=%0d mem[2]=%b, want 0 0 0110",
               anySel, strobes3, mem3[2]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic rspSeen;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 2'd1;
    bus.req_wdata = 4'b1001;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if (bus.mem_rw !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrst_strobe: got rw=%b, want 1", bus.mem_rw);
    end
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({bus.mem_rw, bus.rsp_valid, bus.req_ready, bus.busy, bus.mem_add}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL midrst_abort: got rw=%b rv=%b rdy=%b busy=%b add=%b, want 0 0 1 0 0000",
               bus.mem_rw, bus.rsp_valid, bus.req_ready, bus.busy, bus.mem_add);
    end
    reset   = 1'b0;
    rspSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) rspSeen = 1'b1;
    end
    testsRun++;
    if (rspSeen !== 1'b0 || bus.req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrst_quiet: got rsp=%b rdy=%b, want 0 1", rspSeen, bus.req_ready);
    end
    testsRun++;
    if (mem4[1] !== 4'b0010 && mem4[1] !== 4'b1001) begin
      testsFailed++;
      $display("[TB] FAIL midrst_word: got mem[1]=%b, want 0010 or 1001", mem4[1]);
    end
    testsRun++;
    if (badStrobes !== 0) begin
      testsFailed++;
      $display("[TB] FAIL strobe_onehot: got %0d bad strobes, want 0", badStrobes);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_words();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the team's addressed register-file memory (one-hot word select `add`, `rw` write strobe, parallel data in/out).
- Accepts single-word read/write requests over a valid/ready handshake.
- Sequences the memory's select, data and strobe lines, then returns one response per request.
- Sits between a test/CPU-style sequencer and a WORDS x WIDTH memory array.

Parameters:
- WORDS, 4, number of memory words (one select line each)
- WIDTH, 4, data bits per word
- ADDR_W, 2, request address width; must satisfy 2**ADDR_W >= WORDS

Ports:
- clk  input  1  single clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_rw  input  1  1 = write, 0 = read (same polarity as memory rw)
- req_addr  input  ADDR_W  word address
- req_wdata  input  WIDTH  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  WIDTH  read data; write data echo on writes
- rsp_err  output  1  valid with rsp_valid; address out of range
- mem_add  output  WORDS  one-hot word select to memory
- mem_rw  output  1  write strobe to memory
- mem_din  output  WIDTH  data to memory
- mem_dout  input  WIDTH  data from memory (combinational, gated by select)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk and reset behaviour is as decided: one clock, synchronous active-high reset.
  - reset sampled high at a posedge → state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; mem_add = 0; mem_rw = 0; mem_din = 0; busy = 0.
  - Reset mid-transaction aborts it: no response issued; mem_rw drops the same edge, so no partial write strobe survives.
- States: IDLE, DRIVE, STROBE (write), CAPTURE (read), RESP. All outputs are registered.
- Accept: at a posedge where state = IDLE and req_valid = 1.
  - Latch rw, addr, wdata; go to DRIVE.
  - req_valid while not IDLE is ignored; the requester must hold it.
- DRIVE (1 cycle):
  - mem_add = one-hot(addr); mem_din = wdata (writes) or 0 (reads); mem_rw = 0.
  - Next state is STROBE if write, CAPTURE if read.
- STROBE (1 cycle):
  - mem_add and mem_din held; mem_rw = 1.
  - The memory commits at the posedge ending this cycle.
  - Next state RESP.
- CAPTURE (1 cycle):
  - mem_add held; mem_rw = 0.
  - mem_dout is registered at the posedge ending this cycle.
  - Next state RESP.
- RESP (1 cycle):
  - mem_add = 0; mem_rw = 0; rsp_valid = 1.
  - rsp_rdata = captured data (read) or latched wdata (write).
  - Next state IDLE.
- Latency: accept edge N → rsp_valid high during cycle N+3 → req_ready high again in cycle N+4. Throughput is one request per 4 cycles.
- Out of range (addr >= WORDS):
  - mem_add stays 0 throughout and mem_rw is never asserted.
  - Same state sequence and timing as an in-range request.
  - Response: rsp_err = 1, rsp_rdata = 0 (reads) or wdata echo (writes).
- mem_rw is asserted only in STROBE, and only with exactly one mem_add bit set.
- mem_add/mem_din change only on DRIVE entry and RESP entry; they never glitch during STROBE.
- rsp_err and rsp_rdata are 0 outside RESP.
- busy = ~req_ready.

Test Plan:
- Reset: reset = 1 for 2 cycles with req_valid = 1 → req_ready = 1, all mem_* = 0, no rsp_valid; first request is accepted on the edge after reset falls.
- Write then read:
  - Write addr 2, data 4'b0101 → mem_add = 4'b0100 for 2 cycles, mem_rw = 1 only in the 2nd; rsp_valid at N+3 with rsp_rdata = 0101, rsp_err = 0.
  - Read addr 2 → rsp_rdata = 0101.
- All words: write 0001, 0010, 0100, 1000 to addrs 0..3, read back in reverse → data matches, and other words remain unchanged.
- Back-to-back: hold req_valid = 1 for 3 queued requests → exactly one accept per 4 cycles, req_ready low for 3 of every 4 cycles, 3 responses in order.
- Out of range: WORDS = 3, write addr 3, data 1111 → mem_add = 0, mem_rw never 1, rsp_err = 1; a subsequent read of addr 0 still returns its old value.
- Reset mid-write: assert reset during STROBE → mem_rw = 0 the next cycle, no rsp_valid, state IDLE; the memory word holds either the old or the new value, never a partial one.
